// File: rtl/uart_pkg.sv
// Shared UART constants: data width and default transmit FIFO geometry.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AW    = $clog2(UART_FIFO_DEPTH);
endpackage

// File: rtl/uart_tx_fifo_ram.sv
// Transmit FIFO storage: synchronous write, registered read-first read port.
module uart_tx_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [UART_DATA_W-1:0] rd_data
);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [UART_DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a write to the head slot in the same cycle (full FIFO) returns the old byte.
  always_ff @(posedge clk) begin
    if (reset)      rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO with active-low CPU/transmitter strobes and registered flags.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = UART_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_write_n,
  input  logic [UART_DATA_W-1:0] data_in,
  input  logic                   fifo_read_n,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [AW:0]            fifo_count
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic                   overflow,
  input  logic                   overflow_clr
`endif
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          rd_accept, wr_accept;

  assign rd_accept = ~fifo_read_n & ~empty_q;
  assign wr_accept = ~fifo_write_n & (~full_q | rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // Flags derive from the next count so they land in the same cycle as the count.
    empty_d = (count_d == '0);
    full_d  = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (~fifo_write_n & ~wr_accept) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

  uart_tx_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo; overflow checks follow UART_TX_FIFO_OVERFLOW_EN.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_write_n;
  logic [7:0]    data_in;
  logic          fifo_read_n;
  logic [7:0]    data_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic          overflow;
  logic          overflow_clr;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_write_n (fifo_write_n),
    .data_in      (data_in),
    .fifo_read_n  (fifo_read_n),
    .data_out     (data_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] sb_q[$];
  logic [7:0] exp_dout;
  bit         exp_ovf;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, int'(fifo_count), sb_q.size());
    check({tag, ".empty"}, int'(fifo_empty), int'(sb_q.size() == 0));
    check({tag, ".full"},  int'(fifo_full),  int'(sb_q.size() == DEPTH));
    check({tag, ".dout"},  int'(data_out),   int'(exp_dout));
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check({tag, ".ovf"},   int'(overflow),   int'(exp_ovf));
`endif
  endtask

  // One bus cycle: optional write and/or read, model update, then full state check.
  task automatic op(input string tag, input bit wr, input logic [7:0] din, input bit rd,
                    input bit clr = 1'b0);
    bit rd_acc, wr_acc;
    rd_acc = rd && (sb_q.size() > 0);
    wr_acc = wr && ((sb_q.size() < DEPTH) || rd_acc);
    fifo_write_n = ~wr;
    fifo_read_n  = ~rd;
    data_in      = din;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    overflow_clr = clr;
`endif
    step();
    fifo_write_n = 1'b1;
    fifo_read_n  = 1'b1;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    overflow_clr = 1'b0;
`endif
    if (clr) exp_ovf = 1'b0;
    if (wr && !wr_acc) exp_ovf = 1'b1;
    if (rd_acc) exp_dout = sb_q.pop_front();
    if (wr_acc) sb_q.push_back(din);
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    reset        = 1'b1;
    fifo_write_n = 1'b0;
    fifo_read_n  = 1'b0;
    data_in      = 8'hEE;
    step();
    reset        = 1'b0;
    fifo_write_n = 1'b1;
    fifo_read_n  = 1'b1;
    sb_q.delete();
    exp_dout = 8'h00;
    exp_ovf  = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    fifo_write_n = 1'b1;
    fifo_read_n  = 1'b1;
    data_in      = 8'h00;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    overflow_clr = 1'b0;
`endif
    exp_dout = 8'h00;
    exp_ovf  = 1'b0;
    step();
    step();
    do_reset("reset0");

    op("a5_wr", 1, 8'hA5, 0);
    op("a5_rd", 0, 8'h00, 1);

    for (int i = 0; i < 16; i++) op("fill16", 1, 8'(i), 0);
    op("wr_full_drop", 1, 8'hFF, 0);
    op("idle_full", 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) op("drain16", 0, 8'h00, 1);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    op("ovf_clr", 0, 8'h00, 0, 1'b1);
`endif

    for (int i = 0; i < 16; i++) op("fill_hi", 1, 8'(8'h80 + i), 0);
    op("full_rw55", 1, 8'h55, 1);
    for (int i = 0; i < 16; i++) op("drain_55", 0, 8'h00, 1);

    op("empty_rd", 0, 8'h00, 1);
    op("empty_rw3c", 1, 8'h3C, 1);
    op("rd_3c", 0, 8'h00, 1);

    for (int i = 0; i < 10; i++) op("fill10", 1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 10; i++) op("read10", 0, 8'h00, 1);
    for (int i = 0; i < 12; i++) op("wrap12", 1, 8'(8'hC0 + 3 * i), 0);
    for (int i = 0; i < 12; i++) op("wrap_rd", 0, 8'h00, 1);

    for (int i = 0; i < 5; i++) op("fill5", 1, 8'(8'h60 + i), 0);
    op("rd_one", 0, 8'h00, 1);
    op("wr_one", 1, 8'h99, 0);
    do_reset("reset_mid");
    op("post_rst_wr", 1, 8'h42, 0);
    op("post_rst_rd", 0, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
